// File: rtl/jtag_tap_multi.sv
// jtag_tap_multi: IEEE 1149.1 TAP with IR, bypass, IDCODE and N_CHAN user
// data registers. Each user register captures from and updates to core logic,
// and emits a one-cycle strobe per channel on update.
module jtag_tap_multi #(
    parameter int          IR_WIDTH   = 4,
    parameter int          DR_WIDTH   = 8,
    parameter int          N_CHAN     = 2,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5677,
    parameter int          USER_BASE  = 8
) (
    input  logic                         TCK,
    input  logic                         TRST,
    input  logic                         TMS,
    input  logic                         TDI,
    output logic                         TDO,
    output logic                         TDO_EN,
    input  logic [N_CHAN*DR_WIDTH-1:0]   CAP_DATA,
    output logic [N_CHAN*DR_WIDTH-1:0]   UPD_DATA,
    output logic [N_CHAN-1:0]            UPD_STROBE,
    output logic [IR_WIDTH-1:0]          IR_OUT,
    output logic [3:0]                   TAP_STATE
);

    // TAP state encodings
    localparam logic [3:0] ST_TLR     = 4'h0;
    localparam logic [3:0] ST_RTI     = 4'h1;
    localparam logic [3:0] ST_SEL_DR  = 4'h2;
    localparam logic [3:0] ST_CAP_DR  = 4'h3;
    localparam logic [3:0] ST_SH_DR   = 4'h4;
    localparam logic [3:0] ST_EX1_DR  = 4'h5;
    localparam logic [3:0] ST_PAU_DR  = 4'h6;
    localparam logic [3:0] ST_EX2_DR  = 4'h7;
    localparam logic [3:0] ST_UPD_DR  = 4'h8;
    localparam logic [3:0] ST_SEL_IR  = 4'h9;
    localparam logic [3:0] ST_CAP_IR  = 4'hA;
    localparam logic [3:0] ST_SH_IR   = 4'hB;
    localparam logic [3:0] ST_EX1_IR  = 4'hC;
    localparam logic [3:0] ST_PAU_IR  = 4'hD;
    localparam logic [3:0] ST_EX2_IR  = 4'hE;
    localparam logic [3:0] ST_UPD_IR  = 4'hF;

    localparam logic [IR_WIDTH-1:0] IDCODE_OP  = {{(IR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IR_WIDTH-1:0] BYPASS_OP  = {IR_WIDTH{1'b1}};
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    logic [3:0]                          state_r;
    logic [3:0]                          next_state_s;
    logic [IR_WIDTH-1:0]                 ir_sh_r;
    logic [IR_WIDTH-1:0]                 ir_out_r;
    logic                                bypass_r;
    logic [31:0]                         idcode_sh_r;
    logic [N_CHAN-1:0][DR_WIDTH-1:0]     user_sh_r;
    logic [N_CHAN-1:0][DR_WIDTH-1:0]     upd_data_r;
    logic [N_CHAN-1:0][DR_WIDTH-1:0]     cap_data_s;
    logic [N_CHAN-1:0]                   upd_strobe_r;
    logic [N_CHAN-1:0]                   user_sel_s;
    logic                                sel_idcode_s;
    logic                                sel_bypass_s;
    logic                                user_lsb_s;
    logic                                tdo_s;

    assign cap_data_s = CAP_DATA;

    // Opcode assigned to user channel k
    function automatic logic [IR_WIDTH-1:0] user_op(input int k);
        return IR_WIDTH'(USER_BASE + k);
    endfunction

    // Right shift of a user register with the serial bit entering the MSB;
    // written without a [W-1:1] slice so DR_WIDTH=1 stays legal
    function automatic logic [DR_WIDTH-1:0] dr_shift(input logic [DR_WIDTH-1:0] v,
                                                     input logic b);
        logic [DR_WIDTH-1:0] t;
        t = v >> 1;
        t[DR_WIDTH-1] = b;
        return t;
    endfunction

    // Decode the active instruction into a data-register selection;
    // unknown opcodes fall back to bypass
    always_comb begin
        user_sel_s = {N_CHAN{1'b0}};
        for (int k = 0; k < N_CHAN; k++) begin
            if ((ir_out_r == user_op(k)) && (ir_out_r != BYPASS_OP) && (ir_out_r != IDCODE_OP)) begin
                user_sel_s[k] = 1'b1;
            end else begin
                user_sel_s[k] = 1'b0;
            end
        end
        sel_idcode_s = (ir_out_r == IDCODE_OP);
        sel_bypass_s = !sel_idcode_s && (user_sel_s == {N_CHAN{1'b0}});
    end

    // IEEE 1149.1 next-state function
    always_comb begin
        next_state_s = ST_TLR;
        case (state_r)
            ST_TLR:    next_state_s = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:    next_state_s = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: next_state_s = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: next_state_s = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  next_state_s = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: next_state_s = TMS ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: next_state_s = TMS ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: next_state_s = TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: next_state_s = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: next_state_s = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: next_state_s = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  next_state_s = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: next_state_s = TMS ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: next_state_s = TMS ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: next_state_s = TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: next_state_s = TMS ? ST_SEL_DR : ST_RTI;
            default:   next_state_s = ST_TLR;
        endcase
    end

    // TAP state register
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_r <= ST_TLR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction shift register: capture the fixed 01 pattern, then shift
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_sh_r <= {IR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_CAP_IR: ir_sh_r <= IR_CAPTURE;
                ST_SH_IR:  ir_sh_r <= {TDI, ir_sh_r[IR_WIDTH-1:1]};
                default:   ir_sh_r <= ir_sh_r;
            endcase
        end
    end

    // Active instruction: IDCODE whenever TLR is entered, else latched in UpdIR
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_out_r <= IDCODE_OP;
        end else if (next_state_s == ST_TLR) begin
            ir_out_r <= IDCODE_OP;
        end else if (state_r == ST_UPD_IR) begin
            ir_out_r <= ir_sh_r;
        end else begin
            ir_out_r <= ir_out_r;
        end
    end

    // Bypass bit, active only while bypass is the selected DR
    always_ff @(posedge TCK) begin
        if (TRST) begin
            bypass_r <= 1'b0;
        end else if (sel_bypass_s && (state_r == ST_CAP_DR)) begin
            bypass_r <= 1'b0;
        end else if (sel_bypass_s && (state_r == ST_SH_DR)) begin
            bypass_r <= TDI;
        end else begin
            bypass_r <= bypass_r;
        end
    end

    // IDCODE shift register
    always_ff @(posedge TCK) begin
        if (TRST) begin
            idcode_sh_r <= 32'h0000_0000;
        end else if (sel_idcode_s && (state_r == ST_CAP_DR)) begin
            idcode_sh_r <= IDCODE_VAL;
        end else if (sel_idcode_s && (state_r == ST_SH_DR)) begin
            idcode_sh_r <= {TDI, idcode_sh_r[31:1]};
        end else begin
            idcode_sh_r <= idcode_sh_r;
        end
    end

    // User shift registers; only the selected channel captures or shifts
    always_ff @(posedge TCK) begin
        if (TRST) begin
            user_sh_r <= {(N_CHAN*DR_WIDTH){1'b0}};
        end else begin
            for (int k = 0; k < N_CHAN; k++) begin
                if (user_sel_s[k] && (state_r == ST_CAP_DR)) begin
                    user_sh_r[k] <= cap_data_s[k];
                end else if (user_sel_s[k] && (state_r == ST_SH_DR)) begin
                    user_sh_r[k] <= dr_shift(user_sh_r[k], TDI);
                end else begin
                    user_sh_r[k] <= user_sh_r[k];
                end
            end
        end
    end

    // Parallel update registers and one-cycle strobes for the selected channel
    always_ff @(posedge TCK) begin
        if (TRST) begin
            upd_data_r   <= {(N_CHAN*DR_WIDTH){1'b0}};
            upd_strobe_r <= {N_CHAN{1'b0}};
        end else begin
            for (int k = 0; k < N_CHAN; k++) begin
                if (user_sel_s[k] && (state_r == ST_UPD_DR)) begin
                    upd_data_r[k]   <= user_sh_r[k];
                    upd_strobe_r[k] <= 1'b1;
                end else begin
                    upd_data_r[k]   <= upd_data_r[k];
                    upd_strobe_r[k] <= 1'b0;
                end
            end
        end
    end

    // LSB of whichever user register is selected
    always_comb begin
        user_lsb_s = 1'b0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (user_sel_s[k]) begin
                user_lsb_s = user_lsb_s | user_sh_r[k][0];
            end else begin
                user_lsb_s = user_lsb_s;
            end
        end
    end

    // Serial output mux: combinational so the captured LSB appears with no latency
    always_comb begin
        tdo_s = 1'b0;
        if (state_r == ST_SH_IR) begin
            tdo_s = ir_sh_r[0];
        end else if (state_r == ST_SH_DR) begin
            if (sel_idcode_s) begin
                tdo_s = idcode_sh_r[0];
            end else if (sel_bypass_s) begin
                tdo_s = bypass_r;
            end else begin
                tdo_s = user_lsb_s;
            end
        end else begin
            tdo_s = 1'b0;
        end
    end

    assign TDO        = tdo_s;
    assign TDO_EN     = (state_r == ST_SH_IR) || (state_r == ST_SH_DR);
    assign UPD_DATA   = upd_data_r;
    assign UPD_STROBE = upd_strobe_r;
    assign IR_OUT     = ir_out_r;
    assign TAP_STATE  = state_r;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Self-checking bench for jtag_tap_multi: directed scenarios plus randomized
// TMS/TDI traffic compared every cycle against a behavioural TAP model.
module tb_jtag_tap_multi;

    localparam int          IRW = 4;
    localparam int          DRW = 8;
    localparam int          NCH = 2;
    localparam logic [31:0] IDC = 32'h1234_5677;
    localparam int          UB  = 8;

    logic                 tck = 1'b0;
    logic                 trst;
    logic                 tms;
    logic                 tdi;
    logic                 tdo;
    logic                 tdo_en;
    logic [NCH*DRW-1:0]   cap_data;
    logic [NCH*DRW-1:0]   upd_data;
    logic [NCH-1:0]       upd_strobe;
    logic [IRW-1:0]       ir_out;
    logic [3:0]           tap_state;

    int n_total = 0;
    int n_bad   = 0;
    logic tdo_seen;

    // Behavioural model state
    int          m_state;
    logic [3:0]  m_ir_out;
    logic [3:0]  m_ir_sh;
    logic        m_byp;
    logic [31:0] m_idsh;
    logic [7:0]  m_ush [NCH];
    logic [7:0]  m_upd [NCH];
    logic [1:0]  m_strb;

    // IEEE 1149.1 successor tables, indexed by state, for TMS=0 and TMS=1
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    jtag_tap_multi #(
        .IR_WIDTH(IRW), .DR_WIDTH(DRW), .N_CHAN(NCH),
        .IDCODE_VAL(IDC), .USER_BASE(UB)
    ) dut (
        .TCK(tck), .TRST(trst), .TMS(tms), .TDI(tdi), .TDO(tdo), .TDO_EN(tdo_en),
        .CAP_DATA(cap_data), .UPD_DATA(upd_data), .UPD_STROBE(upd_strobe),
        .IR_OUT(ir_out), .TAP_STATE(tap_state)
    );

    always #5 tck = ~tck;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: which DR the instruction selects (0..NCH-1 user, NCH idcode, NCH+1 bypass)
    function automatic int sel_of(input logic [3:0] ir);
        if (ir == 4'hF) return NCH + 1;
        if (ir == 4'h1) return NCH;
        if ((int'(ir) >= UB) && (int'(ir) < UB + NCH)) return int'(ir) - UB;
        return NCH + 1;
    endfunction

    function automatic logic model_tdo();
        int s;
        s = sel_of(m_ir_out);
        if (m_state == 11) return m_ir_sh[0];
        if (m_state != 4) return 1'b0;
        if (s < NCH) return m_ush[s][0];
        if (s == NCH) return m_idsh[0];
        return m_byp;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ir_out = 4'h1; m_ir_sh = 4'h0; m_byp = 1'b0; m_idsh = 32'h0;
        m_strb = 2'b00;
        for (int k = 0; k < NCH; k++) begin
            m_ush[k] = 8'h00;
            m_upd[k] = 8'h00;
        end
    endtask

    task automatic model_step(input logic t_ms, input logic t_di);
        int s;
        int ns;
        if (trst) begin
            model_reset();
            return;
        end
        s = sel_of(m_ir_out);
        m_strb = 2'b00;
        case (m_state)
            3: begin
                if (s < NCH) m_ush[s] = cap_data[s*DRW +: DRW];
                else if (s == NCH) m_idsh = IDC;
                else m_byp = 1'b0;
            end
            4: begin
                if (s < NCH) m_ush[s] = (m_ush[s] >> 1) | (8'(t_di) << 7);
                else if (s == NCH) m_idsh = (m_idsh >> 1) | (32'(t_di) << 31);
                else m_byp = t_di;
            end
            8: begin
                if (s < NCH) begin
                    m_upd[s] = m_ush[s];
                    m_strb[s] = 1'b1;
                end
            end
            10: m_ir_sh = 4'h1;
            11: m_ir_sh = (m_ir_sh >> 1) | (4'(t_di) << 3);
            15: m_ir_out = m_ir_sh;
            default: ;
        endcase
        ns = t_ms ? nxt1[m_state] : nxt0[m_state];
        if (ns == 0) m_ir_out = 4'h1;
        m_state = ns;
    endtask

    // One TCK: drive, check serial output mid-cycle, clock, check registered outputs
    task automatic tick(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        @(negedge tck);
        tdo_seen = tdo;
        check_eq("tdo", 32'(tdo), 32'(model_tdo()));
        check_eq("tdo_en", 32'(tdo_en), 32'((m_state == 4) || (m_state == 11)));
        @(posedge tck);
        model_step(t_ms, t_di);
        #1;
        check_eq("state", 32'(tap_state), m_state);
        check_eq("ir_out", 32'(ir_out), 32'(m_ir_out));
        check_eq("upd_data", 32'(upd_data), 32'({m_upd[1], m_upd[0]}));
        check_eq("upd_strobe", 32'(upd_strobe), 32'(m_strb));
    endtask

    // Shift n bits LSB-first; optionally raise TMS on the last bit to exit
    task automatic shift_bits(input int n, input logic [63:0] data, input bit exit_last,
                              output logic [63:0] got);
        got = 64'h0;
        for (int i = 0; i < n; i++) begin
            tick(exit_last && (i == n - 1), data[i]);
            got[i] = tdo_seen;
        end
    endtask

    // From RTI: load an instruction and return to RTI; first_bits gets the capture bits
    task automatic load_ir(input logic [3:0] op, output logic [3:0] first_bits);
        logic [63:0] got;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        shift_bits(IRW, 64'(op), 1'b1, got);
        first_bits = got[3:0];
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic goto_shdr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From Ex1DR: pass through UpdDR and land in RTI
    task automatic finish_dr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        trst = 1'b1;
        tick(1'b0, 1'b0);
        trst = 1'b0;
    endtask

    initial begin
        logic [63:0] got;
        logic [3:0]  fb;
        logic [7:0]  d;
        int          n;

        trst = 1'b1; tms = 1'b0; tdi = 1'b0;
        cap_data = {8'hA5, 8'h77};
        @(posedge tck);
        #1;
        model_reset();
        trst = 1'b0;

        // Random start state, then five TMS=1 clocks must land in TLR
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(3, 25);
            for (int i = 0; i < n; i++) tick(1'($urandom), 1'($urandom));
            for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom));
            check_eq("tms5_state", 32'(tap_state), 32'h0);
            check_eq("tms5_ir", 32'(ir_out), 32'h1);
        end

        // Reset values, then IDCODE readout straight from TLR
        do_reset();
        check_eq("rst_state", 32'(tap_state), 32'h0);
        check_eq("rst_ir", 32'(ir_out), 32'h1);
        check_eq("rst_upd", 32'(upd_data), 32'h0);
        check_eq("rst_strobe", 32'(upd_strobe), 32'h0);
        check_eq("rst_tdo_en", 32'(tdo_en), 32'h0);
        tick(1'b0, 1'b0);
        goto_shdr();
        shift_bits(32, 64'h0, 1'b1, got);
        check_eq("idcode_stream", got[31:0], 32'h1234_5677);
        finish_dr();

        // BYPASS: one-cycle delay, no strobe
        load_ir(4'hF, fb);
        check_eq("ir_capture", 32'(fb[1:0]), 32'h1);
        check_eq("ir_bypass", 32'(ir_out), 32'hF);
        goto_shdr();
        shift_bits(4, 64'hD, 1'b0, got);
        check_eq("bypass_stream", 32'(got[3:0]), 32'hA);
        tick(1'b1, 1'b0);
        finish_dr();
        check_eq("bypass_no_strobe", 32'(upd_strobe), 32'h0);

        // Unused opcode behaves as bypass
        load_ir(4'h5, fb);
        check_eq("ir_capture2", 32'(fb[1:0]), 32'h1);
        goto_shdr();
        shift_bits(3, 64'h3, 1'b1, got);
        check_eq("unused_bypass", 32'(got[2:0]), 32'h6);
        finish_dr();
        check_eq("unused_no_strobe", 32'(upd_strobe), 32'h0);

        // USER1 capture/shift/update
        load_ir(4'h9, fb);
        goto_shdr();
        shift_bits(8, 64'h3C, 1'b1, got);
        check_eq("user1_capture", 32'(got[7:0]), 32'hA5);
        finish_dr();
        check_eq("user1_strobe", 32'(upd_strobe), 32'h2);
        check_eq("user1_upd", 32'(upd_data[15:8]), 32'h3C);
        check_eq("user0_kept", 32'(upd_data[7:0]), 32'h00);
        tick(1'b0, 1'b0);
        check_eq("user1_strobe_gone", 32'(upd_strobe), 32'h0);

        // USER0 shift split by a pause, then TRST mid-shift
        d = 8'($urandom);
        load_ir(4'h8, fb);
        goto_shdr();
        shift_bits(4, 64'(d[3:0]), 1'b1, got);
        check_eq("user0_cap_lo", 32'(got[3:0]), 32'h7);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        shift_bits(4, 64'(d[7:4]), 1'b1, got);
        check_eq("user0_cap_hi", 32'(got[3:0]), 32'h7);
        finish_dr();
        check_eq("user0_upd", 32'(upd_data[7:0]), 32'(d));
        check_eq("user0_strobe", 32'(upd_strobe), 32'h1);
        check_eq("user1_kept", 32'(upd_data[15:8]), 32'h3C);
        goto_shdr();
        shift_bits(3, 64'h5, 1'b0, got);
        do_reset();
        check_eq("trst_strobe", 32'(upd_strobe), 32'h0);
        check_eq("trst_upd", 32'(upd_data), 32'h0);
        check_eq("trst_ir", 32'(ir_out), 32'h1);
        check_eq("trst_state", 32'(tap_state), 32'h0);
        tick(1'b0, 1'b0);
        check_eq("trst_no_strobe", 32'(upd_strobe), 32'h0);

        // Randomized traffic against the model
        for (int r = 0; r < 80; r++) begin
            logic [3:0] op;
            cap_data = 16'($urandom);
            case ($urandom_range(0, 4))
                0: op = 4'h1;
                1: op = 4'hF;
                2: op = 4'h8;
                3: op = 4'h9;
                default: op = 4'($urandom);
            endcase
            load_ir(op, fb);
            goto_shdr();
            n = $urandom_range(1, 40);
            shift_bits(n, {$urandom, $urandom}, 1'b1, got);
            if ($urandom_range(0, 2) == 0) begin
                tick(1'b0, 1'b0);
                tick(1'b1, 1'b0);
                tick(1'b0, 1'b0);
                shift_bits($urandom_range(1, 10), {$urandom, $urandom}, 1'b1, got);
            end
            finish_dr();
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) begin
                trst = ($urandom_range(0, 63) == 0);
                tick(1'($urandom), 1'($urandom));
            end
            trst = 1'b0;
            for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
